tesla_sensor_tx: RTL and testbench

Serial transmitter for 4-bit sensor samples carrying a mod-5 check residue. It accepts a sample over a valid/ready handshake and shifts it out MSB-first on a single-wire framed line. The residue (sample % 5) is computed bit-serially while the data bits are sent, so the far end can check the received word against its own remainder computation. It sits on the sensor side of the link, feeding the mod-5 remainder consumer.

---
 rtl/tesla_sensor_pkg.sv | 28 ++
 rtl/mod5_residue_step.sv | 17 +
 rtl/tesla_sensor_tx.sv | 164 ++++++++++++++++
 tb/tb_tesla_sensor_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tesla_sensor_pkg.sv
// Shared types and constants for the tesla_sensor_tx serial transmitter.
// The PAR state exists only when TESLA_SENSOR_TX_PARITY_EN is defined.
package tesla_sensor_pkg;

  localparam int SAMPLE_W = 4;
  localparam int RES_W    = 3;
  localparam logic [3:0] MOD = 4'd5;

  localparam int FRAME_BITS_NOPAR = 9;
  localparam int FRAME_BITS_PAR   = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_RES   = 3'd3,
`ifdef TESLA_SENSOR_TX_PARITY_EN
    ST_PAR   = 3'd4,
`endif
    ST_STOP  = 3'd5
  } state_e;

  // Even parity over data and residue: the bit makes the total count of ones even.
  function automatic logic even_parity(input logic [SAMPLE_W+RES_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mod5_residue_step.sv
// One bit-serial step of the mod-5 remainder: r_next = (2r + b) mod 5.
// Shared with the receiver-side checker so both ends compute identical residues.
module mod5_residue_step
  import tesla_sensor_pkg::*;
(
  input  logic [RES_W-1:0] r_i,
  input  logic             b_i,
  output logic [RES_W-1:0] r_next_o
);

  logic [3:0] sum_s;

  // r is always 0..4, so the sum never exceeds 9 and one subtraction suffices.
  assign sum_s    = {r_i, 1'b0} + {3'b000, b_i};
  assign r_next_o = (sum_s >= MOD) ? 3'(sum_s - MOD) : sum_s[2:0];

endmodule

// File: rtl/tesla_sensor_tx.sv
// Framed MSB-first serial transmitter for 4-bit samples plus mod-5 residue.
// Define TESLA_SENSOR_TX_PARITY_EN to append an even-parity bit before stop.
module tesla_sensor_tx
  import tesla_sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                ser_out,
  output logic                busy,
  output logic                tx_done,
  output logic [RES_W-1:0]    rest_out
);

  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cyc_q, cyc_d;
  logic [1:0]          bit_q, bit_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [RES_W-1:0]    rest_q, rest_d;
  logic                ser_q, ser_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RES_W-1:0]    step_s;
  logic                cur_bit_s;
  logic                bit_end_s;

  assign bit_end_s = (cyc_q == LAST_CYC);
  assign cur_bit_s = data_q[2'd3 - bit_q];

  mod5_residue_step u_step (
    .r_i      (res_q),
    .b_i      (cur_bit_s),
    .r_next_o (step_s)
  );

  // Next state, counters and datapath; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cyc_d   = bit_end_s ? 8'd0 : cyc_q + 8'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    res_d   = res_q;
    rest_d  = rest_q;
    ser_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cyc_d = 8'd0;
        if (in_valid) begin
          state_d = ST_START;
          bit_d   = 2'd0;
          data_d  = in_data;
          res_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          bit_d   = 2'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          res_d = step_s;
          if (bit_q == 2'd3) begin
            state_d = ST_RES;
            bit_d   = 2'd0;
            rest_d  = step_s;
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RES: begin
        if (bit_end_s) begin
          if (bit_q == 2'd2) begin
`ifdef TESLA_SENSOR_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
            bit_d = 2'd0;
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end else begin
          state_d = ST_RES;
        end
      end
`ifdef TESLA_SENSOR_TX_PARITY_EN
      ST_PAR: begin
        if (bit_end_s) state_d = ST_STOP;
        else           state_d = ST_PAR;
      end
`endif
      ST_STOP: begin
        if (bit_end_s) state_d = ST_IDLE;
        else           state_d = ST_STOP;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 8'd0;
      end
    endcase

    case (state_d)
      ST_START: ser_d = 1'b0;
      ST_DATA:  ser_d = data_d[2'd3 - bit_d];
      ST_RES:   ser_d = res_d[2'd2 - bit_d];
`ifdef TESLA_SENSOR_TX_PARITY_EN
      ST_PAR:   ser_d = even_parity({data_d, res_d});
`endif
      default:  ser_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (cyc_d == LAST_CYC);
  end

  // State and output registers; reset forces the line idle and drops the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 8'd0;
      bit_q   <= 2'd0;
      data_q  <= 4'd0;
      res_q   <= 3'd0;
      rest_q  <= 3'd0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      res_q   <= res_d;
      rest_q  <= rest_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign rest_out = rest_q;

endmodule

// File: tb/tb_tesla_sensor_tx.sv
// Directed scoreboard bench for tesla_sensor_tx at CLKS_PER_BIT = 1, 3 and 4.
module tb_tesla_sensor_tx;

`ifdef TESLA_SENSOR_TX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  typedef struct {
    logic [3:0] d;
    logic [2:0] r;
    logic       p;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       vld    [3];
  logic [3:0] din    [3];
  logic       rdy_s  [3];
  logic       ser_s  [3];
  logic       busy_s [3];
  logic       done_s [3];
  logic [2:0] rest_s [3];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tesla_sensor_tx #(.CLKS_PER_BIT((g == 0) ? 1 : (g == 1) ? 3 : 4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (vld[g]),
      .in_data  (din[g]),
      .in_ready (rdy_s[g]),
      .ser_out  (ser_s[g]),
      .busy     (busy_s[g]),
      .tx_done  (done_s[g]),
      .rest_out (rest_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 3 : 4;
  endfunction

  function automatic exp_t mk(input logic [3:0] d);
    exp_t e;
    e.d = d;
    e.r = 3'(d % 4'd5);
    e.p = ^{d, e.r};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after the accept edge; samples every cycle of the frame, then pops and compares.
  task automatic capture(input int idx, input logic [3:0] mid, output logic [9:0] bits);
    int   cpb;
    int   bad_stable;
    int   bad_done;
    int   bad_busy;
    exp_t e;
    cpb = cpb_of(idx);
    bad_stable = 0;
    bad_done = 0;
    bad_busy = 0;
    bits = '1;
    din[idx] = mid;
    for (int j = 0; j < NB * cpb; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j % cpb == 0) bits[NB-1-j/cpb] = ser_s[idx];
      else if (ser_s[idx] !== bits[NB-1-j/cpb]) bad_stable++;
      if (done_s[idx] !== (j == NB * cpb - 1)) bad_done++;
      if (busy_s[idx] !== 1'b1) bad_busy++;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("start_bit", 32'(bits[NB-1]), 32'd0);
    chk("data_bits", 32'(bits[NB-2 -: 4]), 32'(e.d));
    chk("res_bits", 32'(bits[NB-6 -: 3]), 32'(e.r));
`ifdef TESLA_SENSOR_TX_PARITY_EN
    chk("par_bit", 32'(bits[1]), 32'(e.p));
`endif
    chk("stop_bit", 32'(bits[0]), 32'd1);
    chk("bit_stable", 32'(bad_stable), 32'd0);
    chk("done_timing", 32'(bad_done), 32'd0);
    chk("busy_in_frame", 32'(bad_busy), 32'd0);
    chk("rest_out", 32'(rest_s[idx]), 32'(e.r));
    chk("ready_after", 32'(rdy_s[idx]), 32'd1);
    chk("busy_after", 32'(busy_s[idx]), 32'd0);
    chk("done_after", 32'(done_s[idx]), 32'd0);
  endtask

  task automatic send(input int idx, input logic [3:0] d, input logic [3:0] mid, output logic [9:0] bits);
    @(negedge clk);
    chk("ready_before", 32'(rdy_s[idx]), 32'd1);
    vld[idx] = 1'b1;
    din[idx] = d;
    @(posedge clk);
    #1;
    vld[idx] = 1'b0;
    sb.push_back(mk(d));
    capture(idx, mid, bits);
  endtask

  initial begin
    logic [9:0] bits;
    int         t0;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      din[i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(rdy_s[i]), 32'd1);
      chk("rst_ser", 32'(ser_s[i]), 32'd1);
      chk("rst_busy", 32'(busy_s[i]), 32'd0);
      chk("rst_done", 32'(done_s[i]), 32'd0);
      chk("rst_rest", 32'(rest_s[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef TESLA_SENSOR_TX_PARITY_EN
    send(0, 4'hE, 4'h1, bits);
    chk("frame_E", 32'(bits[8:0]), 32'b011101001);
`else
    send(0, 4'h7, 4'h8, bits);
    chk("frame_7_par", 32'(bits), 32'b0011101001);
`endif
    send(0, 4'hF, 4'h0, bits);
    chk("res_F", 32'(bits[NB-6 -: 3]), 32'b000);
    send(0, 4'h5, 4'hA, bits);
    chk("res_5", 32'(bits[NB-6 -: 3]), 32'b000);
    send(0, 4'h9, 4'h6, bits);
    chk("res_9", 32'(bits[NB-6 -: 3]), 32'b100);

    // Back-to-back with in_valid held high; second start must appear one cycle after the frame ends.
    @(negedge clk);
    vld[2] = 1'b1;
    din[2] = 4'h3;
    @(posedge clk);
    #1;
    t0 = cyc;
    sb.push_back(mk(4'h3));
    capture(2, 4'hC, bits);
    @(posedge clk);
    #1;
    chk("spacing", 32'(cyc - t0), 32'd37);
    chk("start2_bit", 32'(ser_s[2]), 32'd0);
    vld[2] = 1'b0;
    sb.push_back(mk(4'hC));
    capture(2, 4'h3, bits);

    // Async reset in the middle of DATA.
    @(negedge clk);
    vld[1] = 1'b1;
    din[1] = 4'h0;
    @(posedge clk);
    #1;
    vld[1] = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy_s[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ser", 32'(ser_s[1]), 32'd1);
    chk("midrst_busy", 32'(busy_s[1]), 32'd0);
    chk("midrst_done", 32'(done_s[1]), 32'd0);
    chk("midrst_ready", 32'(rdy_s[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(rdy_s[1]), 32'd1);
    chk("postrst_ser", 32'(ser_s[1]), 32'd1);
    chk("postrst_rest", 32'(rest_s[1]), 32'd0);
    send(1, 4'hB, 4'h4, bits);

    for (int idx = 0; idx < 2; idx++) begin
      for (int v = 0; v < 16; v++) begin
        send(idx, 4'(v), ~4'(v), bits);
      end
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
